// File: rtl/nn_layer_sequencer_if.sv
// Engine-side fetch handshake between the layer sequencer (master) and the
// compute engine (slave): beat strobes, indices, activation select and ready.
interface nn_layer_sequencer_if #(
    parameter int NW = 6,
    parameter int LW = 4
) ();
    logic          eng_ready;
    logic          weight_en;
    logic          bias_en;
    logic [NW-1:0] n;
    logic [NW-1:0] i;
    logic [LW-1:0] layer;
    logic [1:0]    af_sel;
    logic          neuron_done;

    modport master (
        input  eng_ready,
        output weight_en, bias_en, n, i, layer, af_sel, neuron_done
    );

    modport slave (
        output eng_ready,
        input  weight_en, bias_en, n, i, layer, af_sel, neuron_done
    );
endinterface

// File: rtl/nn_layer_sequencer.sv
// Walks layers/neurons/weights of a small MLP and issues fetch beats to an engine.
// Optional bias beat per neuron enabled by macro NN_SEQ_BIAS_FETCH_EN.
//
// state    | meaning
// IDLE     | waiting for start, configuration checked and latched here
// LOAD     | clears indices, fan-in taken from the latched input size
// WEIGHT   | one weight beat per consumed eng_ready, i walks the fan-in
// BIAS     | single bias beat (only with NN_SEQ_BIAS_FETCH_EN)
// NEND     | neuron_done pulse, advance neuron or layer
// DONE     | done pulse, back to IDLE
module nn_layer_sequencer #(
    parameter int MAX_LAYERS = 8,
    parameter int NW         = 6,
    parameter int LW         = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    input  logic [LW-1:0]            i_no_layers,
    input  logic [NW-1:0]            i_in_size,
    input  logic [MAX_LAYERS*NW-1:0] i_layer_size,
    input  logic [MAX_LAYERS*2-1:0]  i_layer_af,
    nn_layer_sequencer_if.master     eng,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err
);

`ifdef NN_SEQ_BIAS_FETCH_EN
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WEIGHT, S_BIAS, S_NEND, S_DONE} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_WEIGHT, S_NEND, S_DONE} state_t;
`endif

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [LW-1:0]           r_no_layers;
    logic [NW-1:0]           r_in_size;
    logic [MAX_LAYERS*NW-1:0] r_layer_size;
    logic [MAX_LAYERS*2-1:0] r_layer_af;
    logic [NW-1:0]           r_n;
    logic [NW-1:0]           r_i;
    logic [LW-1:0]           r_layer;
    logic [NW-1:0]           r_fanin;
    logic                    r_err;

    logic [NW-1:0] w_cur_size;
    logic [NW-1:0] w_next_size;
    logic [1:0]    w_cur_af;
    logic          w_cfg_ok;
    logic          w_last_i;
    logic          w_last_n;
    logic          w_last_layer;
    logic          w_err_set;

    always_comb begin
        w_cur_size  = '0;
        w_next_size = '0;
        w_cur_af    = '0;
        for (int k = 0; k < MAX_LAYERS; k++) begin
            if (r_layer == LW'(k)) begin
                w_cur_size = r_layer_size[k*NW +: NW];
                w_cur_af   = r_layer_af[k*2 +: 2];
            end
            if ((r_layer + LW'(1)) == LW'(k)) begin
                w_next_size = r_layer_size[k*NW +: NW];
            end
        end
    end

    assign w_cfg_ok     = (i_no_layers != '0) && (i_no_layers <= LW'(MAX_LAYERS)) &&
                          (i_in_size != '0);
    assign w_last_i     = (r_i == (r_fanin - NW'(1)));
    assign w_last_n     = (r_n == (w_cur_size - NW'(1)));
    assign w_last_layer = (r_layer == (r_no_layers - LW'(1)));

    always_comb begin
        w_state_nxt = r_state;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    if (w_cfg_ok) w_state_nxt = S_LOAD;
                    else          w_err_set   = 1'b1;
                end
            end
            S_LOAD: begin
                if (r_layer_size[NW-1:0] == '0) begin
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_WEIGHT;
                end
            end
            S_WEIGHT: begin
                if (eng.eng_ready && w_last_i) begin
`ifdef NN_SEQ_BIAS_FETCH_EN
                    w_state_nxt = S_BIAS;
`else
                    w_state_nxt = S_NEND;
`endif
                end
            end
`ifdef NN_SEQ_BIAS_FETCH_EN
            S_BIAS: begin
                if (eng.eng_ready) w_state_nxt = S_NEND;
            end
`endif
            S_NEND: begin
                if (!w_last_n) begin
                    w_state_nxt = S_WEIGHT;
                end else if (!w_last_layer) begin
                    // next layer's fan-in is this layer's neuron count
                    if (w_next_size == '0) begin
                        w_err_set   = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WEIGHT;
                    end
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= S_IDLE;
            r_no_layers  <= '0;
            r_in_size    <= '0;
            r_layer_size <= '0;
            r_layer_af   <= '0;
            r_n          <= '0;
            r_i          <= '0;
            r_layer      <= '0;
            r_fanin      <= '0;
            r_err        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_err   <= w_err_set;
            case (r_state)
                S_IDLE: begin
                    if (i_start && w_cfg_ok) begin
                        r_no_layers  <= i_no_layers;
                        r_in_size    <= i_in_size;
                        r_layer_size <= i_layer_size;
                        r_layer_af   <= i_layer_af;
                    end
                end
                S_LOAD: begin
                    r_layer <= '0;
                    r_n     <= '0;
                    r_i     <= '0;
                    r_fanin <= r_in_size;
                end
                S_WEIGHT: begin
                    if (eng.eng_ready) r_i <= w_last_i ? '0 : r_i + NW'(1);
                end
                S_NEND: begin
                    if (!w_last_n) begin
                        r_n <= r_n + NW'(1);
                    end else if (!w_last_layer) begin
                        r_layer <= r_layer + LW'(1);
                        r_n     <= '0;
                        r_fanin <= w_cur_size;
                    end
                end
                default: ;
            endcase
            if (w_state_nxt == S_IDLE) begin
                r_n     <= '0;
                r_i     <= '0;
                r_layer <= '0;
            end
        end
    end

    assign eng.weight_en   = (r_state == S_WEIGHT);
`ifdef NN_SEQ_BIAS_FETCH_EN
    assign eng.bias_en     = (r_state == S_BIAS);
`else
    assign eng.bias_en     = 1'b0;
`endif
    assign eng.neuron_done = (r_state == S_NEND);
    assign eng.n           = r_n;
    assign eng.i           = r_i;
    assign eng.layer       = r_layer;
    assign eng.af_sel      = (r_state == S_IDLE) ? 2'b00 : w_cur_af;
    assign o_busy          = (r_state != S_IDLE);
    assign o_done          = (r_state == S_DONE);
    assign o_err           = r_err;

endmodule

// File: tb/tb_nn_layer_sequencer.sv
// Directed self-checking bench for nn_layer_sequencer; expectations follow the
// NN_SEQ_BIAS_FETCH_EN setting of the build.
module tb_nn_layer_sequencer;
`ifdef NN_SEQ_BIAS_FETCH_EN
    localparam bit BIAS = 1'b1;
`else
    localparam bit BIAS = 1'b0;
`endif
    localparam int EXP_DONE1 = BIAS ? 10 : 8;
    localparam int EXP_DONE3 = BIAS ? 34 : 28;
    localparam int EXP_DONE8 = BIAS ? 26 : 18;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  no_layers = '0;
    logic [5:0]  in_size = '0;
    logic [47:0] layer_size = '0;
    logic [15:0] layer_af = '0;
    logic        busy, done, err;

    int checks = 0;
    int failures = 0;

    int m_w, m_b, m_nd, m_overlap, m_done_cyc, m_err_cyc, m_end_cyc;
    int m_wl[16];
    int m_wa[4];

    nn_layer_sequencer_if #(.NW(6), .LW(4)) eng_if ();

    nn_layer_sequencer #(.MAX_LAYERS(8), .NW(6), .LW(4)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_start      (start),
        .i_no_layers  (no_layers),
        .i_in_size    (in_size),
        .i_layer_size (layer_size),
        .i_layer_af   (layer_af),
        .eng          (eng_if),
        .o_busy       (busy),
        .o_done       (done),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    function automatic logic [47:0] pack3(input int s0, input int s1, input int s2);
        logic [47:0] v;
        v = '0;
        v[0 +: 6]  = 6'(s0);
        v[6 +: 6]  = 6'(s1);
        v[12 +: 6] = 6'(s2);
        return v;
    endfunction

    // Leaves the caller on the negedge of the first cycle after start was sampled.
    task automatic start_run(input logic [3:0] nl, input logic [5:0] isz,
                             input logic [47:0] ls, input logic [15:0] af);
        @(negedge clk);
        no_layers  = nl;
        in_size    = isz;
        layer_size = ls;
        layer_af   = af;
        start      = 1'b1;
        @(negedge clk);
        start      = 1'b0;
    endtask

    task automatic run_monitor(input int budget);
        m_w = 0; m_b = 0; m_nd = 0; m_overlap = 0;
        m_done_cyc = 0; m_err_cyc = 0; m_end_cyc = 0;
        for (int k = 0; k < 16; k++) m_wl[k] = 0;
        for (int k = 0; k < 4; k++)  m_wa[k] = 0;
        for (int c = 1; c <= budget; c++) begin
            if (eng_if.weight_en && eng_if.eng_ready) begin
                m_w++;
                m_wl[eng_if.layer]++;
                m_wa[eng_if.af_sel]++;
            end
            if (eng_if.bias_en && eng_if.eng_ready) m_b++;
            if (eng_if.weight_en && eng_if.bias_en) m_overlap++;
            if (eng_if.neuron_done) m_nd++;
            if (done && m_done_cyc == 0) m_done_cyc = c;
            if (err && m_err_cyc == 0) m_err_cyc = c;
            if (!busy) begin
                m_end_cyc = c;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b0; eng_if.eng_ready = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({eng_if.weight_en, eng_if.bias_en, eng_if.n, eng_if.i, eng_if.layer,
             eng_if.af_sel, eng_if.neuron_done, busy, done, err} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got we=%b be=%b n=%0d i=%0d layer=%0d af=%0d nd=%b busy=%b done=%b err=%b, want all 0",
                     eng_if.weight_en, eng_if.bias_en, eng_if.n, eng_if.i, eng_if.layer,
                     eng_if.af_sel, eng_if.neuron_done, busy, done, err);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_busy: got %b want 0", busy); end
    endtask

    task automatic test_single_layer;
        start_run(4'd1, 6'd2, pack3(2, 0, 0), 16'h0003);
        run_monitor(100);
        checks++;
        if (m_done_cyc != EXP_DONE1) begin failures++; $display("FAIL single_done_cycle: got %0d want %0d", m_done_cyc, EXP_DONE1); end
        checks++;
        if (m_w != 4) begin failures++; $display("FAIL single_weight_beats: got %0d want 4", m_w); end
        checks++;
        if (m_b != (BIAS ? 2 : 0)) begin failures++; $display("FAIL single_bias_beats: got %0d want %0d", m_b, BIAS ? 2 : 0); end
        checks++;
        if (m_nd != 2) begin failures++; $display("FAIL single_neuron_done: got %0d want 2", m_nd); end
        checks++;
        if (m_wa[3] != 4) begin failures++; $display("FAIL single_af_sel: got %0d beats with af 3, want 4", m_wa[3]); end
        checks++;
        if (m_overlap != 0 || m_err_cyc != 0) begin
            failures++; $display("FAIL single_overlap_err: got overlap=%0d err_cycle=%0d want 0 0", m_overlap, m_err_cyc);
        end
        checks++;
        if (m_end_cyc != EXP_DONE1 + 1 || eng_if.af_sel !== 2'd0) begin
            failures++; $display("FAIL single_return_idle: got end=%0d af=%0d want end=%0d af=0", m_end_cyc, eng_if.af_sel, EXP_DONE1 + 1);
        end
    endtask

    task automatic test_multi_layer;
        start_run(4'd3, 6'd4, pack3(3, 2, 1), 16'h0039);
        no_layers = '0; in_size = '0; layer_size = '1; layer_af = '0;
        run_monitor(200);
        checks++;
        if (m_done_cyc != EXP_DONE3) begin failures++; $display("FAIL multi_done_cycle: got %0d want %0d", m_done_cyc, EXP_DONE3); end
        checks++;
        if (m_w != 20) begin failures++; $display("FAIL multi_weight_beats: got %0d want 20", m_w); end
        checks++;
        if (m_wl[0] != 12 || m_wl[1] != 6 || m_wl[2] != 2) begin
            failures++; $display("FAIL multi_beats_per_layer: got %0d/%0d/%0d want 12/6/2", m_wl[0], m_wl[1], m_wl[2]);
        end
        checks++;
        if (m_wa[0] != 0 || m_wa[1] != 12 || m_wa[2] != 6 || m_wa[3] != 2) begin
            failures++; $display("FAIL multi_af_tracking: got %0d/%0d/%0d/%0d want 0/12/6/2", m_wa[0], m_wa[1], m_wa[2], m_wa[3]);
        end
        checks++;
        if (m_nd != 6) begin failures++; $display("FAIL multi_neuron_done: got %0d want 6", m_nd); end
        checks++;
        if (m_b != (BIAS ? 6 : 0)) begin failures++; $display("FAIL multi_bias_beats: got %0d want %0d", m_b, BIAS ? 6 : 0); end
        checks++;
        if (m_err_cyc != 0 || m_overlap != 0) begin
            failures++; $display("FAIL multi_err_overlap: got err_cycle=%0d overlap=%0d want 0 0", m_err_cyc, m_overlap);
        end
    endtask

    task automatic test_stall;
        bit held_ok;
        start_run(4'd1, 6'd3, pack3(1, 0, 0), 16'h0000);
        checks++;
        if (busy !== 1'b1 || eng_if.weight_en !== 1'b0) begin
            failures++; $display("FAIL stall_load_cycle: got busy=%b we=%b want 1 0", busy, eng_if.weight_en);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (eng_if.weight_en !== 1'b1 || eng_if.i !== 6'd1) begin
            failures++; $display("FAIL stall_reach_i1: got we=%b i=%0d want 1 1", eng_if.weight_en, eng_if.i);
        end
        eng_if.eng_ready = 1'b0;
        held_ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (eng_if.weight_en !== 1'b1 || eng_if.i !== 6'd1 || eng_if.n !== 6'd0) held_ok = 1'b0;
        end
        checks++;
        if (!held_ok) begin
            failures++; $display("FAIL stall_hold: got we=%b i=%0d n=%0d during stall want 1 1 0", eng_if.weight_en, eng_if.i, eng_if.n);
        end
        eng_if.eng_ready = 1'b1;
        run_monitor(50);
        checks++;
        if (m_w != 2) begin failures++; $display("FAIL stall_resume_beats: got %0d want 2", m_w); end
        checks++;
        if (m_done_cyc == 0 || m_nd != 1) begin
            failures++; $display("FAIL stall_completion: got done_cycle=%0d nd=%0d want nonzero 1", m_done_cyc, m_nd);
        end
    endtask

    task automatic test_errors;
        start_run(4'd0, 6'd2, pack3(2, 0, 0), 16'h0000);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_zero_layers: got err=%b busy=%b want 1 0", err, busy); end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin failures++; $display("FAIL err_pulse_width: got err=%b want 0", err); end

        start_run(4'd9, 6'd2, pack3(2, 0, 0), 16'h0000);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_too_many_layers: got err=%b busy=%b want 1 0", err, busy); end

        start_run(4'd1, 6'd0, pack3(2, 0, 0), 16'h0000);
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin failures++; $display("FAIL err_in_size_zero: got err=%b busy=%b want 1 0", err, busy); end

        start_run(4'd1, 6'd2, pack3(0, 0, 0), 16'h0000);
        run_monitor(20);
        checks++;
        if (m_err_cyc != 2 || m_end_cyc != 2 || m_done_cyc != 0) begin
            failures++; $display("FAIL err_size0_zero: got err=%0d end=%0d done=%0d want 2 2 0", m_err_cyc, m_end_cyc, m_done_cyc);
        end

        start_run(4'd2, 6'd1, pack3(1, 0, 0), 16'h0000);
        run_monitor(50);
        checks++;
        if (m_err_cyc != (BIAS ? 5 : 4) || m_end_cyc != m_err_cyc || m_done_cyc != 0) begin
            failures++; $display("FAIL err_size1_zero: got err=%0d end=%0d done=%0d want %0d %0d 0",
                                 m_err_cyc, m_end_cyc, m_done_cyc, BIAS ? 5 : 4, BIAS ? 5 : 4);
        end

        start_run(4'd8, 6'd1, 48'h0410_4104_1041, 16'h0000);
        run_monitor(100);
        checks++;
        if (m_done_cyc != EXP_DONE8 || m_w != 8 || m_err_cyc != 0) begin
            failures++; $display("FAIL max_layers_run: got done=%0d w=%0d err=%0d want %0d 8 0", m_done_cyc, m_w, m_err_cyc, EXP_DONE8);
        end
    endtask

    task automatic test_reset_mid_run;
        bit found;
        found = 1'b0;
        start_run(4'd3, 6'd4, pack3(3, 2, 1), 16'h0039);
        for (int c = 0; c < 100; c++) begin
            if ((BIAS ? eng_if.bias_en : eng_if.weight_en) && eng_if.layer == 4'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin failures++; $display("FAIL rstmid_reach_layer1: got no fetch beat in layer 1 within 100 cycles"); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({eng_if.weight_en, eng_if.bias_en, eng_if.n, eng_if.i, eng_if.layer,
             eng_if.af_sel, eng_if.neuron_done, busy, done, err} !== '0) begin
            failures++; $display("FAIL rstmid_outputs: got we=%b be=%b n=%0d i=%0d layer=%0d af=%0d busy=%b want all 0",
                                 eng_if.weight_en, eng_if.bias_en, eng_if.n, eng_if.i, eng_if.layer, eng_if.af_sel, busy);
        end
        rst = 1'b0;
        start_run(4'd1, 6'd2, pack3(2, 0, 0), 16'h0000);
        checks++;
        if (eng_if.layer !== 4'd0 || busy !== 1'b1) begin
            failures++; $display("FAIL rstmid_restart: got layer=%0d busy=%b want 0 1", eng_if.layer, busy);
        end
        run_monitor(100);
        checks++;
        if (m_done_cyc != EXP_DONE1 || m_w != 4 || m_nd != 2) begin
            failures++; $display("FAIL rstmid_fresh_run: got done=%0d w=%0d nd=%0d want %0d 4 2", m_done_cyc, m_w, m_nd, EXP_DONE1);
        end
    endtask

    initial begin
        eng_if.eng_ready = 1'b1;
        test_reset();
        test_single_layer();
        test_multi_layer();
        test_stall();
        test_errors();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running at 200000, want finished");
        $fatal(1, "watchdog expired");
    end
endmodule
